// File: rtl/sar_scan_sequencer.sv
// rtl/sar_scan_sequencer.sv - multi-channel SAR scan sequencer with settle, watchdog and continuous mode
// Define SAR_SCAN_AVG_EN to convert each channel four times and report the truncated mean.
module sar_scan_sequencer #(
  parameter int Width         = 6,
  parameter int NumCh         = 4,
  parameter int ChW           = 2,
  parameter int SettleCycles  = 2,
  parameter int TimeoutCycles = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             scan_i,
  input  logic             cont_i,
  input  logic [NumCh-1:0] ch_mask_i,
  output logic             sar_start_o,
  input  logic             sar_eoc_i,
  input  logic [Width-1:0] sar_result_i,
  output logic [ChW-1:0]   ch_sel_o,
  output logic [Width-1:0] data_o,
  output logic [ChW-1:0]   data_ch_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             scan_done_o,
  output logic             err_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETTLE = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_STORE  = 3'd4;

  localparam logic [3:0] SettleLast = 4'(SettleCycles - 1);
  localparam logic [7:0] WaitLast   = 8'(TimeoutCycles - 1);

  logic [2:0]       state_q, state_d;
  logic [NumCh-1:0] mask_q, mask_d;
  logic [ChW-1:0]   ch_sel_q, ch_sel_d;
  logic [ChW-1:0]   data_ch_q, data_ch_d;
  logic [Width-1:0] data_q, data_d;
  logic [3:0]       settle_q, settle_d;
  logic [7:0]       wait_q, wait_d;
  logic             err_q, err_d;
  logic             empty_done_q, empty_done_d;
  logic [NumCh-1:0] above;
  logic             has_above;
`ifdef SAR_SCAN_AVG_EN
  logic [1:0]       conv_q, conv_d;
  logic [Width+1:0] acc_q, acc_d, acc_sum;
`endif

  function automatic logic [ChW-1:0] lowest_ch(input logic [NumCh-1:0] m);
    lowest_ch = '0;
    for (int i = NumCh - 1; i >= 0; i--) begin
      if (m[i]) lowest_ch = ChW'(i);
    end
  endfunction

  // Enabled channels strictly above the one currently selected.
  always_comb begin
    above = '0;
    for (int i = 0; i < NumCh; i++) begin
      above[i] = mask_q[i] && (i > int'(ch_sel_q));
    end
    has_above = |above;
  end

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    ch_sel_d     = ch_sel_q;
    data_d       = data_q;
    data_ch_d    = data_ch_q;
    settle_d     = settle_q;
    wait_d       = wait_q;
    err_d        = err_q;
    empty_done_d = 1'b0;
`ifdef SAR_SCAN_AVG_EN
    conv_d       = conv_q;
    acc_d        = acc_q;
    acc_sum      = acc_q + {2'b00, sar_result_i};
`endif
    case (state_q)
      S_IDLE: begin
        if (scan_i) begin
          mask_d = ch_mask_i;
          err_d  = 1'b0;
          if (ch_mask_i == '0) begin
            empty_done_d = 1'b1;
          end else begin
            ch_sel_d = lowest_ch(ch_mask_i);
            settle_d = '0;
            state_d  = S_SETTLE;
`ifdef SAR_SCAN_AVG_EN
            conv_d   = '0;
            acc_d    = '0;
`endif
          end
        end
      end
      S_SETTLE: begin
        if (settle_q == SettleLast) state_d = S_START;
        else settle_d = settle_q + 4'd1;
      end
      S_START: begin
        wait_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // An eoc on the last allowed cycle takes priority over the timeout.
        if (sar_eoc_i) begin
`ifdef SAR_SCAN_AVG_EN
          if (conv_q == 2'd3) begin
            data_d    = acc_sum[Width+1:2];
            data_ch_d = ch_sel_q;
            state_d   = S_STORE;
          end else begin
            acc_d   = acc_sum;
            conv_d  = conv_q + 2'd1;
            state_d = S_START;
          end
`else
          data_d    = sar_result_i;
          data_ch_d = ch_sel_q;
          state_d   = S_STORE;
`endif
        end else if (wait_q == WaitLast) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_STORE: begin
        if (has_above) begin
          ch_sel_d = lowest_ch(above);
          settle_d = '0;
          state_d  = S_SETTLE;
`ifdef SAR_SCAN_AVG_EN
          conv_d   = '0;
          acc_d    = '0;
`endif
        end else if (cont_i && (ch_mask_i != '0)) begin
          mask_d   = ch_mask_i;
          ch_sel_d = lowest_ch(ch_mask_i);
          settle_d = '0;
          state_d  = S_SETTLE;
`ifdef SAR_SCAN_AVG_EN
          conv_d   = '0;
          acc_d    = '0;
`endif
        end else begin
          if (cont_i) mask_d = ch_mask_i;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      mask_q       <= '0;
      ch_sel_q     <= '0;
      data_q       <= '0;
      data_ch_q    <= '0;
      settle_q     <= '0;
      wait_q       <= '0;
      err_q        <= 1'b0;
      empty_done_q <= 1'b0;
`ifdef SAR_SCAN_AVG_EN
      conv_q       <= '0;
      acc_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      ch_sel_q     <= ch_sel_d;
      data_q       <= data_d;
      data_ch_q    <= data_ch_d;
      settle_q     <= settle_d;
      wait_q       <= wait_d;
      err_q        <= err_d;
      empty_done_q <= empty_done_d;
`ifdef SAR_SCAN_AVG_EN
      conv_q       <= conv_d;
      acc_q        <= acc_d;
`endif
    end
  end

  assign sar_start_o = (state_q == S_START);
  assign valid_o     = (state_q == S_STORE);
  assign busy_o      = (state_q != S_IDLE);
  assign scan_done_o = empty_done_q || ((state_q == S_STORE) && !has_above);
  assign ch_sel_o    = ch_sel_q;
  assign data_o      = data_q;
  assign data_ch_o   = data_ch_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_sar_scan_sequencer.sv
// tb/tb_sar_scan_sequencer.sv - scoreboard bench for sar_scan_sequencer (SettleCycles=3, TimeoutCycles=10)
module tb_sar_scan_sequencer;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       scan_i;
  logic       cont_i;
  logic [3:0] ch_mask_i;
  logic       sar_start_o;
  logic       sar_eoc_i;
  logic [5:0] sar_result_i;
  logic [1:0] ch_sel_o;
  logic [5:0] data_o;
  logic [1:0] data_ch_o;
  logic       valid_o;
  logic       busy_o;
  logic       scan_done_o;
  logic       err_o;

  sar_scan_sequencer #(
    .Width(6), .NumCh(4), .ChW(2), .SettleCycles(3), .TimeoutCycles(10)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .scan_i(scan_i), .cont_i(cont_i),
    .ch_mask_i(ch_mask_i), .sar_start_o(sar_start_o), .sar_eoc_i(sar_eoc_i),
    .sar_result_i(sar_result_i), .ch_sel_o(ch_sel_o), .data_o(data_o),
    .data_ch_o(data_ch_o), .valid_o(valid_o), .busy_o(busy_o),
    .scan_done_o(scan_done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0] ch;
    logic [5:0] data;
    logic       done;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         start_cnt = 0;
  int         eoc_delay = 8;
  logic       eoc_block = 1'b0;
  logic       ramp = 1'b0;
  int         conv_k = 0;
  logic [5:0] res_tab [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] ch, input logic [5:0] data, input logic done);
    exp_t e;
    e.ch = ch; e.data = data; e.done = done;
    sb.push_back(e);
  endtask

  // SAR converter model: eoc arrives eoc_delay cycles after each start.
  initial begin
    logic [1:0] ch;
    sar_eoc_i    = 1'b0;
    sar_result_i = '0;
    forever begin
      @(negedge clk_i);
      while (sar_start_o && !eoc_block) begin
        ch = ch_sel_o;
        start_cnt++;
        repeat (eoc_delay) @(negedge clk_i);
        check("ch_sel_stable", 32'(ch_sel_o), 32'(ch));
        sar_eoc_i    = 1'b1;
        sar_result_i = ramp ? 6'(10 + conv_k) : res_tab[ch];
        conv_k++;
        @(negedge clk_i);
        sar_eoc_i = 1'b0;
      end
    end
  end

  // Monitor: every valid strobe pops one expectation.
  always @(negedge clk_i) begin
    exp_t e;
    if (valid_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: ch %0d data %0h with nothing expected", data_ch_o, data_o);
      end else begin
        e = sb.pop_front();
        check("valid_ch", 32'(data_ch_o), 32'(e.ch));
        check("valid_data", 32'(data_o), 32'(e.data));
        check("valid_done", 32'(scan_done_o), 32'(e.done));
      end
    end
  end

  task automatic scan_timed(input logic [3:0] mask, input logic [1:0] first_ch);
    int n;
    ch_mask_i = mask;
    scan_i    = 1'b1;
    @(negedge clk_i);
    scan_i = 1'b0;
    check("accept_busy", 32'(busy_o), 32'd1);
    check("accept_ch_sel", 32'(ch_sel_o), 32'(first_ch));
    n = 1;
    while (!sar_start_o && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    check("start_latency", 32'(n), 32'd4);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy_o && n < 600) begin
      @(negedge clk_i);
      n++;
    end
    check(name, 32'(busy_o), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int nv;
    int s;
    logic done_seen;
    res_tab[0] = 6'h05; res_tab[1] = 6'h1A; res_tab[2] = 6'h2F; res_tab[3] = 6'h3F;
    rst_i = 1'b1; scan_i = 1'b0; cont_i = 1'b0; ch_mask_i = '0;
    repeat (3) @(negedge clk_i);
    check("reset_outputs",
          32'({sar_start_o, ch_sel_o, data_o, data_ch_o, valid_o, busy_o, scan_done_o, err_o}), 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Full mask; mask change after accept must not affect this scan.
    push(2'd0, 6'h05, 1'b0); push(2'd1, 6'h1A, 1'b0);
    push(2'd2, 6'h2F, 1'b0); push(2'd3, 6'h3F, 1'b1);
    scan_timed(4'b1111, 2'd0);
    ch_mask_i = 4'b0001;
    wait_idle("full_scan_idle");
    check("full_scan_drained", 32'(sb.size()), 32'd0);

    // Sparse mask
    push(2'd1, 6'h1A, 1'b0); push(2'd3, 6'h3F, 1'b1);
    scan_timed(4'b1010, 2'd1);
    wait_idle("sparse_idle");
    check("sparse_drained", 32'(sb.size()), 32'd0);

    // Empty mask
    s = start_cnt;
    ch_mask_i = 4'b0000; scan_i = 1'b1;
    @(negedge clk_i);
    scan_i = 1'b0;
    check("empty_done", 32'(scan_done_o), 32'd1);
    check("empty_busy", 32'(busy_o), 32'd0);
    @(negedge clk_i);
    check("empty_done_pulse", 32'(scan_done_o), 32'd0);
    repeat (5) @(negedge clk_i);
    check("empty_no_start", 32'(start_cnt - s), 32'd0);

    // Continuous mode on ch0, dropped at the second strobe
    s = start_cnt;
    push(2'd0, 6'h05, 1'b1); push(2'd0, 6'h05, 1'b1);
    cont_i = 1'b1;
    scan_timed(4'b0001, 2'd0);
    nv = 0; n = 0;
    while (nv < 2 && n < 400) begin
      @(negedge clk_i);
      n++;
      if (valid_o) nv++;
    end
    cont_i = 1'b0;
    check("cont_valid_count", 32'(nv), 32'd2);
    wait_idle("cont_idle");
    repeat (20) @(negedge clk_i);
    check("cont_start_count", 32'(start_cnt - s), 32'd2);
    check("cont_drained", 32'(sb.size()), 32'd0);

    // Eoc on the final watchdog cycle wins
    eoc_delay = 10;
    push(2'd2, 6'h2F, 1'b1);
    scan_timed(4'b0100, 2'd2);
    wait_idle("late_eoc_idle");
    check("late_eoc_no_err", 32'(err_o), 32'd0);
    eoc_delay = 8;

    // Watchdog timeout
    eoc_block = 1'b1;
    ch_mask_i = 4'b0001; scan_i = 1'b1;
    @(negedge clk_i);
    scan_i = 1'b0;
    n = 1; done_seen = 1'b0;
    while (!err_o && n < 40) begin
      @(negedge clk_i);
      n++;
      if (scan_done_o) done_seen = 1'b1;
    end
    check("timeout_err_cycle", 32'(n), 32'd15);
    check("timeout_idle", 32'(busy_o), 32'd0);
    check("timeout_no_done", 32'(done_seen), 32'd0);
    repeat (3) @(negedge clk_i);
    check("err_sticky", 32'(err_o), 32'd1);
    eoc_block = 1'b0;
    ch_mask_i = 4'b0000; scan_i = 1'b1;
    @(negedge clk_i);
    scan_i = 1'b0;
    check("err_cleared", 32'(err_o), 32'd0);

    // Reset during WAIT
    eoc_block = 1'b1;
    scan_timed(4'b0001, 2'd0);
    repeat (2) @(negedge clk_i);
    check("pre_reset_busy", 32'(busy_o), 32'd1);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("reset_mid_wait",
          32'({sar_start_o, ch_sel_o, data_o, data_ch_o, valid_o, busy_o, scan_done_o, err_o}), 32'd0);
    rst_i = 1'b0;
    eoc_block = 1'b0;
    @(negedge clk_i);

    // Recovery after reset
    push(2'd3, 6'h3F, 1'b1);
    scan_timed(4'b1000, 2'd3);
    wait_idle("recover_idle");

`ifdef SAR_SCAN_AVG_EN
    // Results 10,11,12,13 average to 11
    ramp = 1'b1; conv_k = 0;
    push(2'd0, 6'd11, 1'b1);
    scan_timed(4'b0001, 2'd0);
    wait_idle("avg_idle");
    ramp = 1'b0;
`endif

    repeat (5) @(negedge clk_i);
    check("final_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
